cpu_ctrl_fsm_param: RTL and testbench

//  Parametrised multicycle control FSM for the 16-bit RISC machine; drives the datapath, IR, PC and data-address regs.

---
 rtl/cpu_ctrl_fsm_param.sv | 219 +++++++++++++++++++++
 tb/tb_cpu_ctrl_fsm_param.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_fsm_param.sv
// Multicycle control FSM for the 16-bit RISC datapath (variable-latency memory, timeout, sticky ERR; BRANCH_EN adds conditional branches).
// Latency: Moore outputs decoded from the state register; one state per cycle, and memory states last until mem_ready.
// Backpressure: IF1/LDR_MEM/STR_MEM stall on mem_ready low; after MAX_WAIT stalled cycles the FSM enters ERR (MAX_WAIT=0 disables the timeout).
module cpu_ctrl_fsm_param #(
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       opcode,
    input  logic [1:0]       op,
    input  logic [2:0]       cond,
    input  logic [2:0]       Rn,
    input  logic [2:0]       Rd,
    input  logic [2:0]       Rm,
    input  logic             N,
    input  logic             V,
    input  logic             Z,
    input  logic             mem_ready,
    output logic [2:0]       readnum,
    output logic [2:0]       writenum,
    output logic             write,
    output logic             loada,
    output logic             loadb,
    output logic             loadc,
    output logic             loads,
    output logic             asel,
    output logic             bsel,
    output logic [1:0]       vsel,
    output logic             load_ir,
    output logic             load_pc,
    output logic             reset_pc,
    output logic             load_addr,
    output logic             addr_sel,
    output logic             pc_branch,
    output logic [1:0]       mem_cmd,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    localparam logic [1:0] MREAD  = 2'd1;
    localparam logic [1:0] MNONE  = 2'd2;
    localparam logic [1:0] MWRITE = 2'd3;

    localparam int WC_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WC_W-1:0] WAIT_LIM = WC_W'(MAX_WAIT);

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPD_PC, S_DECODE, S_MOVI,
        S_MOVR_B, S_MOVR_C, S_MOVR_WR,
        S_ALU_B, S_ALU_A, S_ALU_C, S_ALU_S, S_ALU_WR,
        S_LDR_A, S_LDR_C, S_LDR_ADDR, S_LDR_MEM, S_LDR_WR,
        S_STR_A, S_STR_C, S_STR_ADDR, S_STR_B, S_STR_C2, S_STR_MEM,
        S_BR, S_HALT, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              timeout;
    logic              br_taken;
    logic              br_valid;

`ifdef BRANCH_EN
    always_comb begin
        br_taken = 1'b0;
        br_valid = 1'b1;
        case (cond)
            3'b000:  br_taken = 1'b1;
            3'b001:  br_taken = Z;
            3'b010:  br_taken = ~Z;
            3'b011:  br_taken = N ^ V;
            3'b100:  br_taken = (N ^ V) | Z;
            default: br_valid = 1'b0;
        endcase
    end
`else
    logic unused_br;
    assign unused_br = ^{cond, N, V, Z};
    assign br_taken  = 1'b0;
    assign br_valid  = 1'b0;
`endif

    // mem_ready is tested first in every wait state, so a late ready still wins over the timeout.
    assign timeout = (MAX_WAIT != 0) && (wait_cnt_q == WAIT_LIM);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:      state_d = S_IF1;
            S_IF1:      if (mem_ready) state_d = S_IF2; else if (timeout) state_d = S_ERR;
            S_IF2:      state_d = S_UPD_PC;
            S_UPD_PC:   state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    3'b110: begin
                        if (op == 2'b10)      state_d = S_MOVI;
                        else if (op == 2'b00) state_d = S_MOVR_B;
                        else                  state_d = S_ERR;
                    end
                    3'b101:  state_d = S_ALU_B;
                    3'b011:  state_d = (op == 2'b00) ? S_LDR_A : S_ERR;
                    3'b100:  state_d = (op == 2'b00) ? S_STR_A : S_ERR;
                    3'b111:  state_d = S_HALT;
`ifdef BRANCH_EN
                    3'b001:  state_d = S_BR;
`endif
                    default: state_d = S_ERR;
                endcase
            end
            S_MOVI:     state_d = S_IF1;
            S_MOVR_B:   state_d = S_MOVR_C;
            S_MOVR_C:   state_d = S_MOVR_WR;
            S_MOVR_WR:  state_d = S_IF1;
            S_ALU_B:    state_d = (op == 2'b11) ? S_ALU_C : S_ALU_A;
            S_ALU_A:    state_d = (op == 2'b01) ? S_ALU_S : S_ALU_C;
            S_ALU_C:    state_d = S_ALU_WR;
            S_ALU_S:    state_d = S_IF1;
            S_ALU_WR:   state_d = S_IF1;
            S_LDR_A:    state_d = S_LDR_C;
            S_LDR_C:    state_d = S_LDR_ADDR;
            S_LDR_ADDR: state_d = S_LDR_MEM;
            S_LDR_MEM:  if (mem_ready) state_d = S_LDR_WR; else if (timeout) state_d = S_ERR;
            S_LDR_WR:   state_d = S_IF1;
            S_STR_A:    state_d = S_STR_C;
            S_STR_C:    state_d = S_STR_ADDR;
            S_STR_ADDR: state_d = S_STR_B;
            S_STR_B:    state_d = S_STR_C2;
            S_STR_C2:   state_d = S_STR_MEM;
            S_STR_MEM:  if (mem_ready) state_d = S_IF1; else if (timeout) state_d = S_ERR;
            S_BR:       state_d = br_valid ? S_IF1 : S_ERR;
            S_HALT:     state_d = S_HALT;
            S_ERR:      state_d = S_ERR;
            default:    state_d = S_ERR;
        endcase
    end

    // The counter only runs while a wait state holds; any transition, including entry, clears it.
    always_comb begin
        wait_cnt_d = '0;
        if ((state_d == state_q) &&
            (state_q == S_IF1 || state_q == S_LDR_MEM || state_q == S_STR_MEM))
            wait_cnt_d = wait_cnt_q + 1'b1;
    end

    always_comb begin
        retired_d = retired_q;
        if (state_d == S_IF1 && state_q != S_IF1 && state_q != S_RST)
            retired_d = retired_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_RST;
            wait_cnt_q <= '0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            retired_q  <= retired_d;
        end
    end

    assign retired = retired_q;

    always_comb begin
        readnum   = 3'd0;
        writenum  = 3'd0;
        write     = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        vsel      = 2'd0;
        load_ir   = 1'b0;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        load_addr = 1'b0;
        addr_sel  = 1'b0;
        pc_branch = 1'b0;
        mem_cmd   = MNONE;
        halted    = 1'b0;
        err       = 1'b0;
        case (state_q)
            S_RST:      begin reset_pc = 1'b1; load_pc = 1'b1; end
            S_IF1:      begin addr_sel = 1'b1; mem_cmd = MREAD; end
            S_IF2:      begin addr_sel = 1'b1; mem_cmd = MREAD; load_ir = 1'b1; end
            S_UPD_PC:   load_pc = 1'b1;
            S_MOVI:     begin write = 1'b1; writenum = Rn; vsel = 2'd2; end
            S_MOVR_B:   begin readnum = Rm; loadb = 1'b1; end
            S_MOVR_C:   begin asel = 1'b1; loadc = 1'b1; end
            S_MOVR_WR:  begin write = 1'b1; writenum = Rd; end
            S_ALU_B:    begin readnum = Rm; loadb = 1'b1; end
            S_ALU_A:    begin readnum = Rn; loada = 1'b1; end
            S_ALU_C:    loadc = 1'b1;
            S_ALU_S:    loads = 1'b1;
            S_ALU_WR:   begin write = 1'b1; writenum = Rd; end
            S_LDR_A,
            S_STR_A:    begin readnum = Rn; loada = 1'b1; bsel = 1'b1; end
            S_LDR_C,
            S_STR_C:    begin loadc = 1'b1; bsel = 1'b1; end
            S_LDR_ADDR,
            S_STR_ADDR: load_addr = 1'b1;
            S_LDR_MEM:  mem_cmd = MREAD;
            S_LDR_WR:   begin write = 1'b1; writenum = Rd; vsel = 2'd3; mem_cmd = MREAD; end
            S_STR_B:    begin readnum = Rd; loadb = 1'b1; asel = 1'b1; end
            S_STR_C2:   begin loadc = 1'b1; asel = 1'b1; end
            S_STR_MEM:  mem_cmd = MWRITE;
            S_BR:       begin load_pc = br_taken; pc_branch = br_taken; end
            S_HALT:     halted = 1'b1;
            S_ERR:      err = 1'b1;
            default:    ;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm_param.sv
// Directed bench for cpu_ctrl_fsm_param: walks every instruction path, memory stalls, timeout, ERR/HALT and async reset.
// Outputs are sampled on the falling edge, and inputs change there too.
module tb_cpu_ctrl_fsm_param;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  opcode, cond, Rn, Rd, Rm;
    logic [1:0]  op;
    logic        N, V, Z, mem_ready;
    logic [2:0]  readnum, writenum;
    logic        write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  vsel, mem_cmd;
    logic        load_ir, load_pc, reset_pc, load_addr, addr_sel, pc_branch, halted, err;
    logic [15:0] retired;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_ctrl_fsm_param #(.MAX_WAIT(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .op(op), .cond(cond),
        .Rn(Rn), .Rd(Rd), .Rm(Rm), .N(N), .V(V), .Z(Z), .mem_ready(mem_ready),
        .readnum(readnum), .writenum(writenum), .write(write), .loada(loada),
        .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
        .vsel(vsel), .load_ir(load_ir), .load_pc(load_pc), .reset_pc(reset_pc),
        .load_addr(load_addr), .addr_sel(addr_sel), .pc_branch(pc_branch),
        .mem_cmd(mem_cmd), .halted(halted), .err(err), .retired(retired)
    );

    localparam logic [14:0] F_WRITE = 15'h4000, F_LOADA = 15'h2000, F_LOADB = 15'h1000,
                            F_LOADC = 15'h0800, F_LOADS = 15'h0400, F_ASEL  = 15'h0200,
                            F_BSEL  = 15'h0100, F_LDIR  = 15'h0080, F_LDPC  = 15'h0040,
                            F_RSTPC = 15'h0020, F_LDADR = 15'h0010, F_ADSEL = 15'h0008,
                            F_PCBR  = 15'h0004, F_HALT  = 15'h0002, F_ERR   = 15'h0001;
    localparam logic [1:0] MR = 2'd1, MN = 2'd2, MW = 2'd3;

    logic [24:0] obs;
    assign obs = {write, loada, loadb, loadc, loads, asel, bsel, load_ir, load_pc, reset_pc,
                  load_addr, addr_sel, pc_branch, halted, err, vsel, mem_cmd, readnum, writenum};

    function automatic logic [24:0] E(input logic [14:0] f, input logic [1:0] vs, input logic [1:0] mc,
                                      input logic [2:0] rn, input logic [2:0] wn);
        return {f, vs, mc, rn, wn};
    endfunction

    logic [24:0] RSTe, IF1e, IF2e, UPDe, NONEe, ERRe, HALTe;
    initial begin
        RSTe  = E(F_RSTPC | F_LDPC, 2'd0, MN, 3'd0, 3'd0);
        IF1e  = E(F_ADSEL, 2'd0, MR, 3'd0, 3'd0);
        IF2e  = E(F_ADSEL | F_LDIR, 2'd0, MR, 3'd0, 3'd0);
        UPDe  = E(F_LDPC, 2'd0, MN, 3'd0, 3'd0);
        NONEe = E(15'h0, 2'd0, MN, 3'd0, 3'd0);
        ERRe  = E(F_ERR, 2'd0, MN, 3'd0, 3'd0);
        HALTe = E(F_HALT, 2'd0, MN, 3'd0, 3'd0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input string tag, input logic [24:0] e);
        @(negedge clk);
        check(tag, 32'(obs), 32'(e));
    endtask

    task automatic instr(input logic [2:0] oc, input logic [1:0] o, input logic [2:0] rn,
                         input logic [2:0] rd, input logic [2:0] rm, input logic [2:0] cd);
        opcode = oc; op = o; Rn = rn; Rd = rd; Rm = rm; cond = cd;
    endtask

    task automatic fetch_rest(input string tag);
        cyc({tag, "_if2"}, IF2e);
        cyc({tag, "_upd"}, UPDe);
        cyc({tag, "_dec"}, NONEe);
    endtask

    task automatic ret_is(input string tag, input logic [15:0] e);
        check(tag, 32'(retired), 32'(e));
    endtask

    // Asserts reset mid-cycle, checks the async response, then releases and checks IF1.
    task automatic rst_pulse(input string tag);
        reset = 1'b0;
        #1;
        check({tag, "_rst"}, 32'(obs), 32'(RSTe));
        ret_is({tag, "_rst_ret"}, 16'd0);
        @(negedge clk);
        check({tag, "_rst_hold"}, 32'(obs), 32'(RSTe));
        reset = 1'b1;
        cyc({tag, "_if1"}, IF1e);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; mem_ready = 1'b1; N = 1'b0; V = 1'b0; Z = 1'b0;
        instr(3'b110, 2'b10, 3'd3, 3'd0, 3'd0, 3'd0);
        #1;
        rst_pulse("por");

        // MOVI R3
        fetch_rest("movi");
        cyc("movi_wr", E(F_WRITE, 2'd2, MN, 3'd0, 3'd3));
        ret_is("movi_ret0", 16'd0);
        cyc("movi_if1", IF1e);
        ret_is("movi_ret1", 16'd1);

        // LDR R5,[R2] with three stalled cycles in LDR_MEM
        instr(3'b011, 2'b00, 3'd2, 3'd5, 3'd0, 3'd0);
        fetch_rest("ldr");
        cyc("ldr_a", E(F_LOADA | F_BSEL, 2'd0, MN, 3'd2, 3'd0));
        cyc("ldr_c", E(F_LOADC | F_BSEL, 2'd0, MN, 3'd0, 3'd0));
        cyc("ldr_addr", E(F_LDADR, 2'd0, MN, 3'd0, 3'd0));
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc("ldr_mem", E(15'h0, 2'd0, MR, 3'd0, 3'd0));
        mem_ready = 1'b1;
        cyc("ldr_wr", E(F_WRITE, 2'd3, MR, 3'd0, 3'd5));
        cyc("ldr_if1", IF1e);
        ret_is("ldr_ret", 16'd2);

        // ADD R2 = R1 + R3
        instr(3'b101, 2'b00, 3'd1, 3'd2, 3'd3, 3'd0);
        fetch_rest("add");
        cyc("add_b", E(F_LOADB, 2'd0, MN, 3'd3, 3'd0));
        cyc("add_a", E(F_LOADA, 2'd0, MN, 3'd1, 3'd0));
        cyc("add_c", E(F_LOADC, 2'd0, MN, 3'd0, 3'd0));
        cyc("add_wr", E(F_WRITE, 2'd0, MN, 3'd0, 3'd2));
        cyc("add_if1", IF1e);
        ret_is("add_ret", 16'd3);

        // CMP R1, R3
        instr(3'b101, 2'b01, 3'd1, 3'd0, 3'd3, 3'd0);
        fetch_rest("cmp");
        cyc("cmp_b", E(F_LOADB, 2'd0, MN, 3'd3, 3'd0));
        cyc("cmp_a", E(F_LOADA, 2'd0, MN, 3'd1, 3'd0));
        cyc("cmp_s", E(F_LOADS, 2'd0, MN, 3'd0, 3'd0));
        cyc("cmp_if1", IF1e);
        ret_is("cmp_ret", 16'd4);

        // MVN R7, R6 skips LOADA
        instr(3'b101, 2'b11, 3'd0, 3'd7, 3'd6, 3'd0);
        fetch_rest("mvn");
        cyc("mvn_b", E(F_LOADB, 2'd0, MN, 3'd6, 3'd0));
        cyc("mvn_c", E(F_LOADC, 2'd0, MN, 3'd0, 3'd0));
        cyc("mvn_wr", E(F_WRITE, 2'd0, MN, 3'd0, 3'd7));
        cyc("mvn_if1", IF1e);
        ret_is("mvn_ret", 16'd5);

        // MOV R1, R5
        instr(3'b110, 2'b00, 3'd0, 3'd1, 3'd5, 3'd0);
        fetch_rest("movr");
        cyc("movr_b", E(F_LOADB, 2'd0, MN, 3'd5, 3'd0));
        cyc("movr_c", E(F_LOADC | F_ASEL, 2'd0, MN, 3'd0, 3'd0));
        cyc("movr_wr", E(F_WRITE, 2'd0, MN, 3'd0, 3'd1));
        cyc("movr_if1", IF1e);
        ret_is("movr_ret", 16'd6);

        // STR R4,[R1]
        instr(3'b100, 2'b00, 3'd1, 3'd4, 3'd0, 3'd0);
        fetch_rest("str");
        cyc("str_a", E(F_LOADA | F_BSEL, 2'd0, MN, 3'd1, 3'd0));
        cyc("str_c", E(F_LOADC | F_BSEL, 2'd0, MN, 3'd0, 3'd0));
        cyc("str_addr", E(F_LDADR, 2'd0, MN, 3'd0, 3'd0));
        cyc("str_b", E(F_LOADB | F_ASEL, 2'd0, MN, 3'd4, 3'd0));
        cyc("str_c2", E(F_LOADC | F_ASEL, 2'd0, MN, 3'd0, 3'd0));
        cyc("str_mem", E(15'h0, 2'd0, MW, 3'd0, 3'd0));
        cyc("str_if1", IF1e);
        ret_is("str_ret", 16'd7);

`ifdef BRANCH_EN
        instr(3'b001, 2'b00, 3'd0, 3'd0, 3'd0, 3'b001);
        Z = 1'b1;
        fetch_rest("beq_t");
        cyc("beq_t_br", E(F_LDPC | F_PCBR, 2'd0, MN, 3'd0, 3'd0));
        cyc("beq_t_if1", IF1e);
        ret_is("beq_t_ret", 16'd8);
        Z = 1'b0;
        fetch_rest("beq_nt");
        cyc("beq_nt_br", NONEe);
        cyc("beq_nt_if1", IF1e);
        ret_is("beq_nt_ret", 16'd9);
        instr(3'b001, 2'b00, 3'd0, 3'd0, 3'd0, 3'b101);
        fetch_rest("bres");
        cyc("bres_br", NONEe);
        cyc("bres_err", ERRe);
`else
        instr(3'b001, 2'b00, 3'd0, 3'd0, 3'd0, 3'b001);
        fetch_rest("br_off");
        cyc("br_off_err", ERRe);
        check("br_off_pcbr", 32'(pc_branch), 32'd0);
`endif
        rst_pulse("after_br");

        // Illegal opcode 010 -> sticky ERR
        instr(3'b010, 2'b00, 3'd0, 3'd0, 3'd0, 3'd0);
        fetch_rest("ill");
        for (int i = 0; i < 3; i++) cyc("ill_err", ERRe);
        rst_pulse("after_ill");

        // MOVI then STR interrupted by reset in STR_C2
        instr(3'b110, 2'b10, 3'd3, 3'd0, 3'd0, 3'd0);
        fetch_rest("movi2");
        cyc("movi2_wr", E(F_WRITE, 2'd2, MN, 3'd0, 3'd3));
        cyc("movi2_if1", IF1e);
        ret_is("movi2_ret", 16'd1);
        instr(3'b100, 2'b00, 3'd1, 3'd4, 3'd0, 3'd0);
        fetch_rest("str2");
        cyc("str2_a", E(F_LOADA | F_BSEL, 2'd0, MN, 3'd1, 3'd0));
        cyc("str2_c", E(F_LOADC | F_BSEL, 2'd0, MN, 3'd0, 3'd0));
        cyc("str2_addr", E(F_LDADR, 2'd0, MN, 3'd0, 3'd0));
        cyc("str2_b", E(F_LOADB | F_ASEL, 2'd0, MN, 3'd4, 3'd0));
        cyc("str2_c2", E(F_LOADC | F_ASEL, 2'd0, MN, 3'd0, 3'd0));
        #2;
        mem_ready = 1'b0;
        rst_pulse("str2");

        // mem_ready stuck low: IF1 for 9 cycles total, then ERR
        for (int i = 1; i < 9; i++) cyc("to_if1", IF1e);
        for (int i = 0; i < 3; i++) cyc("to_err", ERRe);
        mem_ready = 1'b1;
        rst_pulse("after_to");

        // HALT is absorbing
        instr(3'b111, 2'b00, 3'd0, 3'd0, 3'd0, 3'd0);
        fetch_rest("halt");
        cyc("halt_1", HALTe);
        cyc("halt_2", HALTe);
        ret_is("halt_ret", 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
